// File: rtl/vtb_dma_pkg.sv
// Shared types and constants for the video TX frame DMA reader.
package vtb_dma_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, REQ, DRAIN, DONE} dmaState_t;

    localparam logic lpUfiCmdRead = 1'b1;

    // Counters that can reach the FIFO depth itself need one extra bit.
    function automatic int creditWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vtb_frame_dma_reader_if.sv
// UFI read-master bus plus the pixel stream toward the dual-clock FIFO.
interface vtb_frame_dma_reader_if #(
    parameter int pBusAdrsBit  = 32,
    parameter int pUfiBusWidth = 12
);
    logic [pBusAdrsBit-1:0]  oMUfiAdrs;
    logic                    oMUfiREd;
    logic                    oMUfiVd;
    logic                    oMUfiCmd;
    logic                    iMUfiRdy;
    logic [pUfiBusWidth-1:0] iMUfiRd;
    logic                    iMUfiREd;
    logic [pUfiBusWidth-1:0] oPixWd;
    logic                    oPixVd;
    logic                    iPixRdy;

    modport master (
        output oMUfiAdrs, oMUfiREd, oMUfiVd, oMUfiCmd, oPixWd, oPixVd,
        input  iMUfiRdy, iMUfiRd, iMUfiREd, iPixRdy
    );

    modport slave (
        input  oMUfiAdrs, oMUfiREd, oMUfiVd, oMUfiCmd, oPixWd, oPixVd,
        output iMUfiRdy, iMUfiRd, iMUfiREd, iPixRdy
    );
endinterface

// File: rtl/vtb_dma_fifo.sv
// First-word-fall-through return-data FIFO with an occupancy count for credit tracking.
module vtb_dma_fifo
    import vtb_dma_pkg::*;
#(
    parameter int pWidth = 12,
    parameter int pDepth = 64
) (
    input  logic                             iSysClk,
    input  logic                             iSysRst,
    input  logic                             iWrEn,
    input  logic [pWidth-1:0]                iWrData,
    input  logic                             iRdEn,
    output logic [pWidth-1:0]                oRdData,
    output logic                             oEmpty,
    output logic                             oFull,
    output logic [creditWidth(pDepth)-1:0]   oCount
);
    localparam int lpPtrW = $clog2(pDepth);
    localparam int lpCntW = creditWidth(pDepth);

    logic [pWidth-1:0] mem [pDepth];
    logic [lpPtrW-1:0] wrPtr;
    logic [lpPtrW-1:0] rdPtr;
    logic [lpCntW-1:0] count;
    logic              doWrite;
    logic              doRead;

    assign doWrite = iWrEn && !oFull;
    assign doRead  = iRdEn && !oEmpty;
    assign oEmpty  = (count == '0);
    assign oFull   = (count == lpCntW'(pDepth));
    assign oCount  = count;
    // Head word is presented combinationally; forced to zero while empty.
    assign oRdData = oEmpty ? '0 : mem[rdPtr];

    always_ff @(posedge iSysClk) begin
        if (doWrite) begin
            mem[wrPtr] <= iWrData;
        end
    end

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doRead) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doWrite, doRead})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vtb_frame_dma_reader.sv
// Double-buffered frame reader: walks buf1/buf2 over UFI and streams words out in order.
module vtb_frame_dma_reader
    import vtb_dma_pkg::*;
#(
    parameter int pBusAdrsBit   = 32,
    parameter int pUfiBusWidth  = 12,
    parameter int pMemAdrsWidth = 19,
    parameter int pFifoDepth    = 64
) (
    input  logic                     iSysClk,
    input  logic                     iSysRst,
    input  logic                     iDmaEn,
    input  logic [pMemAdrsWidth-1:0] iFbufAdrs1,
    input  logic [pMemAdrsWidth-1:0] iFbufLen1,
    input  logic [pMemAdrsWidth-1:0] iFbufAdrs2,
    input  logic [pMemAdrsWidth-1:0] iFbufLen2,
    vtb_frame_dma_reader_if.master   ufi,
    output logic                     oFrameSel,
    output logic                     oFrameDone,
    output logic                     oOverflow
);
    localparam int lpCW = creditWidth(pFifoDepth);

    dmaState_t                state;
    logic [pMemAdrsWidth-1:0] rBase;
    logic [pMemAdrsWidth-1:0] rRemain;
    logic [pMemAdrsWidth-1:0] rOffset;
    logic [pMemAdrsWidth-1:0] rLen;
    logic [pMemAdrsWidth-1:0] rDelivered;
    logic [pMemAdrsWidth-1:0] curAdrs;
    logic [lpCW-1:0]          outstanding;
    logic [lpCW-1:0]          fifoCount;
    logic [lpCW-1:0]          credit;
    logic                     fifoEmpty;
    logic                     fifoFull;
    logic                     reqAccept;
    logic                     rdAccept;
    logic                     pixPop;

    // Every issued read reserves a FIFO slot, so returned data always has room.
    assign credit        = lpCW'(pFifoDepth) - fifoCount - outstanding;
    assign ufi.oMUfiREd  = (state == REQ) && (rRemain != '0) && (credit != '0) && iDmaEn;
    assign ufi.oMUfiVd   = (state == REQ) || (state == DRAIN);
    assign ufi.oMUfiCmd  = lpUfiCmdRead;
    assign curAdrs       = rBase + rOffset;
    assign ufi.oMUfiAdrs = pBusAdrsBit'(curAdrs);
    assign reqAccept     = ufi.oMUfiREd && ufi.iMUfiRdy;
    // Returns with nothing outstanding (e.g. left over from before a reset) are discarded.
    assign rdAccept      = ufi.iMUfiREd && (outstanding != '0);
    assign ufi.oPixVd    = !fifoEmpty;
    assign pixPop        = ufi.oPixVd && ufi.iPixRdy;

    vtb_dma_fifo #(
        .pWidth (pUfiBusWidth),
        .pDepth (pFifoDepth)
    ) uFifo (
        .iSysClk (iSysClk),
        .iSysRst (iSysRst),
        .iWrEn   (rdAccept),
        .iWrData (ufi.iMUfiRd),
        .iRdEn   (pixPop),
        .oRdData (ufi.oPixWd),
        .oEmpty  (fifoEmpty),
        .oFull   (fifoFull),
        .oCount  (fifoCount)
    );

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            outstanding <= '0;
            oOverflow   <= 1'b0;
        end else begin
            case ({reqAccept, rdAccept})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (ufi.iMUfiREd && fifoFull) begin
                oOverflow <= 1'b1;
            end
        end
    end

    // IDLE also waits for the FIFO to empty so words from an aborted buffer
    // are never counted against the next one.
    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            state      <= IDLE;
            rBase      <= '0;
            rRemain    <= '0;
            rOffset    <= '0;
            rLen       <= '0;
            rDelivered <= '0;
            oFrameSel  <= 1'b0;
            oFrameDone <= 1'b0;
        end else begin
            oFrameDone <= 1'b0;
            if (pixPop) begin
                rDelivered <= rDelivered + 1'b1;
            end
            if (reqAccept) begin
                rOffset <= rOffset + 1'b1;
                rRemain <= rRemain - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (iDmaEn && fifoEmpty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    rBase      <= oFrameSel ? iFbufAdrs2 : iFbufAdrs1;
                    rRemain    <= oFrameSel ? iFbufLen2 : iFbufLen1;
                    rLen       <= oFrameSel ? iFbufLen2 : iFbufLen1;
                    rOffset    <= '0;
                    rDelivered <= '0;
                    state      <= ((oFrameSel ? iFbufLen2 : iFbufLen1) == '0) ? DONE : REQ;
                end
                REQ: begin
                    if (!iDmaEn || (reqAccept && (rRemain == pMemAdrsWidth'(1)))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        if (rRemain == '0) begin
                            state <= DONE;
                        end else begin
                            state     <= IDLE;
                            oFrameSel <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (rDelivered == rLen) begin
                        oFrameDone <= 1'b1;
                        oFrameSel  <= ~oFrameSel;
                        state      <= iDmaEn ? LOAD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vtb_frame_dma_reader.sv
// Directed bench for the frame DMA reader with a RAM model (RAM[a] = a) of configurable latency.
module tb_vtb_frame_dma_reader;
    import vtb_dma_pkg::*;

    logic        iSysClk = 1'b0;
    logic        iSysRst = 1'b1;
    logic        iDmaEn  = 1'b0;
    logic [18:0] iFbufAdrs1 = '0;
    logic [18:0] iFbufLen1  = '0;
    logic [18:0] iFbufAdrs2 = '0;
    logic [18:0] iFbufLen2  = '0;
    logic        oFrameSel;
    logic        oFrameDone;
    logic        oOverflow;

    vtb_frame_dma_reader_if #(.pBusAdrsBit(32), .pUfiBusWidth(12)) ufi ();

    vtb_frame_dma_reader #(
        .pBusAdrsBit   (32),
        .pUfiBusWidth  (12),
        .pMemAdrsWidth (19),
        .pFifoDepth    (64)
    ) dut (
        .iSysClk    (iSysClk),
        .iSysRst    (iSysRst),
        .iDmaEn     (iDmaEn),
        .iFbufAdrs1 (iFbufAdrs1),
        .iFbufLen1  (iFbufLen1),
        .iFbufAdrs2 (iFbufAdrs2),
        .iFbufLen2  (iFbufLen2),
        .ufi        (ufi),
        .oFrameSel  (oFrameSel),
        .oFrameDone (oFrameDone),
        .oOverflow  (oOverflow)
    );

    always #5 iSysClk = ~iSysClk;

    int          totalChecks = 0;
    int          badChecks   = 0;
    int          readLat     = 1;
    bit          rdyToggle   = 1'b0;
    bit          pixRdy      = 1'b1;
    bit          injectStray = 1'b0;
    int          stallErr    = 0;
    bit          stallPrev   = 1'b0;
    logic [31:0] adrsPrev    = '0;
    logic [31:0] accQ[$];
    logic [11:0] pixQ[$];
    bit          doneSelQ[$];
    int          doneAtQ[$];
    logic        pv[8];
    logic [11:0] pd[8];

    // Bus slave, RAM model and stream monitor: drive at negedge+1, sample at negedge+2.
    initial begin
        for (int i = 0; i < 8; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        ufi.iMUfiRdy = 1'b1;
        ufi.iMUfiREd = 1'b0;
        ufi.iMUfiRd  = '0;
        ufi.iPixRdy  = 1'b1;
        forever begin
            @(negedge iSysClk);
            #1;
            ufi.iMUfiRdy = rdyToggle ? ~ufi.iMUfiRdy : 1'b1;
            ufi.iPixRdy  = pixRdy;
            ufi.iMUfiREd = pv[readLat-1] | injectStray;
            ufi.iMUfiRd  = injectStray ? 12'hABC : pd[readLat-1];
            injectStray  = 1'b0;
            for (int i = 7; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = 1'b0;
            #1;
            if (ufi.oMUfiREd && ufi.iMUfiRdy) begin
                accQ.push_back(ufi.oMUfiAdrs);
                pv[0] = 1'b1;
                pd[0] = ufi.oMUfiAdrs[11:0];
            end
            if (stallPrev && ufi.oMUfiREd && (ufi.oMUfiAdrs != adrsPrev)) stallErr++;
            stallPrev = ufi.oMUfiREd && !ufi.iMUfiRdy;
            adrsPrev  = ufi.oMUfiAdrs;
            if (oFrameDone) begin
                doneSelQ.push_back(oFrameSel);
                doneAtQ.push_back(pixQ.size());
            end
            if (ufi.oPixVd && ufi.iPixRdy) pixQ.push_back(ufi.oPixWd);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge iSysClk);
    endtask

    task automatic applyStimulus(input logic [18:0] b1, input logic [18:0] n1,
                                 input logic [18:0] b2, input logic [18:0] n2,
                                 input int lat, input bit rdyT, input bit pix);
        iFbufAdrs1 = b1;
        iFbufLen1  = n1;
        iFbufAdrs2 = b2;
        iFbufLen2  = n2;
        readLat    = lat;
        rdyToggle  = rdyT;
        pixRdy     = pix;
    endtask

    // Long enough for the RAM model pipeline to flush any in-flight returns.
    task automatic doReset();
        iDmaEn  = 1'b0;
        iSysRst = 1'b1;
        tick(8);
        accQ.delete();
        pixQ.delete();
        doneSelQ.delete();
        doneAtQ.delete();
        stallErr = 0;
        iSysRst  = 1'b0;
        tick(2);
    endtask

    function automatic logic [31:0] accAt(input int i);
        return (i < accQ.size()) ? accQ[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pixAt(input int i);
        return (i < pixQ.size()) ? 32'(pixQ[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        $display("[TB] start");
        doReset();
        checkOutput("rst_adrs", ufi.oMUfiAdrs, 0);
        checkOutput("rst_red", 32'(ufi.oMUfiREd), 0);
        checkOutput("rst_vd", 32'(ufi.oMUfiVd), 0);
        checkOutput("rst_cmd", 32'(ufi.oMUfiCmd), 1);
        checkOutput("rst_pixvd", 32'(ufi.oPixVd), 0);
        checkOutput("rst_pixwd", 32'(ufi.oPixWd), 0);
        checkOutput("rst_sel", 32'(oFrameSel), 0);
        checkOutput("rst_done", 32'(oFrameDone), 0);
        checkOutput("rst_ovf", 32'(oOverflow), 0);

        // Two full buffers back to back.
        applyStimulus(19'd0, 19'd8, 19'd100, 19'd8, 1, 1'b0, 1'b1);
        iDmaEn = 1'b1;
        for (int c = 0; c < 400 && doneSelQ.size() < 2; c++) tick();
        iDmaEn = 1'b0;
        tick(30);
        checkOutput("t1_done_cnt", doneSelQ.size(), 2);
        checkOutput("t1_acc_cnt", accQ.size(), 16);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t1_adrs%0d", i), accAt(i), (i < 8) ? i : 92 + i);
            checkOutput($sformatf("t1_pix%0d", i), pixAt(i), (i < 8) ? i : 92 + i);
        end
        if (doneSelQ.size() >= 2) begin
            checkOutput("t1_sel_after1", 32'(doneSelQ[0]), 1);
            checkOutput("t1_sel_after2", 32'(doneSelQ[1]), 0);
            checkOutput("t1_done_at1", doneAtQ[0], 8);
            checkOutput("t1_done_at2", doneAtQ[1], 16);
        end
        doReset();

        // Back-pressure fills the FIFO exactly; stray return while full flags overflow.
        applyStimulus(19'd0, 19'd200, 19'd300, 19'd8, 1, 1'b0, 1'b0);
        iDmaEn = 1'b1;
        tick(150);
        checkOutput("t2_acc_cnt", accQ.size(), 64);
        checkOutput("t2_red_off", 32'(ufi.oMUfiREd), 0);
        checkOutput("t2_ovf_clear", 32'(oOverflow), 0);
        checkOutput("t2_pixvd", 32'(ufi.oPixVd), 1);
        injectStray = 1'b1;
        tick(2);
        checkOutput("t2_ovf_set", 32'(oOverflow), 1);
        pixRdy = 1'b1;
        for (int c = 0; c < 2000 && (pixQ.size() < 200 || doneSelQ.size() < 1); c++) tick();
        iDmaEn = 1'b0;
        checkOutput("t2_pix_cnt_ge", 32'(pixQ.size() >= 200), 1);
        for (int i = 0; i < 200; i++) checkOutput($sformatf("t2_pix%0d", i), pixAt(i), i);
        checkOutput("t2_done_cnt_ge", 32'(doneSelQ.size() >= 1), 1);
        if (doneAtQ.size() >= 1) checkOutput("t2_done_at", doneAtQ[0], 200);
        tick(40);
        doReset();

        // Rdy toggling every cycle: address held through each stall.
        applyStimulus(19'd40, 19'd5, 19'd500, 19'd0, 1, 1'b1, 1'b1);
        iDmaEn = 1'b1;
        for (int c = 0; c < 200 && doneSelQ.size() < 1; c++) tick();
        iDmaEn = 1'b0;
        tick(20);
        checkOutput("t3_acc_cnt", accQ.size(), 5);
        checkOutput("t3_stall_err", stallErr, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t3_adrs%0d", i), accAt(i), 40 + i);
            checkOutput($sformatf("t3_pix%0d", i), pixAt(i), 40 + i);
        end
        doReset();

        // Abort after three accepts with two-cycle read latency, then restart.
        applyStimulus(19'd20, 19'd10, 19'd600, 19'd4, 2, 1'b0, 1'b1);
        iDmaEn = 1'b1;
        for (int c = 0; c < 100 && accQ.size() < 3; c++) tick();
        iDmaEn = 1'b0;
        tick(20);
        checkOutput("t4_acc_cnt", accQ.size(), 3);
        checkOutput("t4_pix_cnt", pixQ.size(), 3);
        for (int i = 0; i < 3; i++) checkOutput($sformatf("t4_pix%0d", i), pixAt(i), 20 + i);
        checkOutput("t4_no_done", doneSelQ.size(), 0);
        checkOutput("t4_sel", 32'(oFrameSel), 0);
        checkOutput("t4_vd", 32'(ufi.oMUfiVd), 0);
        checkOutput("t4_state", 32'(dut.state), 32'(IDLE));
        accQ.delete();
        pixQ.delete();
        iDmaEn = 1'b1;
        for (int c = 0; c < 50 && accQ.size() < 1; c++) tick();
        checkOutput("t4_restart_adrs", accAt(0), 20);
        checkOutput("t4_restart_sel", 32'(oFrameSel), 0);
        iDmaEn = 1'b0;
        tick(30);
        doReset();

        // Zero-length buffer 1 then a short buffer 2.
        applyStimulus(19'd0, 19'd0, 19'd60, 19'd4, 1, 1'b0, 1'b1);
        iDmaEn = 1'b1;
        for (int c = 0; c < 50 && doneSelQ.size() < 1; c++) tick();
        checkOutput("t5_no_bus", accQ.size(), 0);
        if (doneSelQ.size() >= 1) checkOutput("t5_sel_after0", 32'(doneSelQ[0]), 1);
        for (int c = 0; c < 100 && doneSelQ.size() < 2; c++) tick();
        iDmaEn = 1'b0;
        tick(20);
        checkOutput("t5_acc_cnt", accQ.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t5_adrs%0d", i), accAt(i), 60 + i);
            checkOutput($sformatf("t5_pix%0d", i), pixAt(i), 60 + i);
        end
        if (doneAtQ.size() >= 2) checkOutput("t5_done_at2", doneAtQ[1], 4);
        doReset();

        // Asynchronous reset with three reads in flight; late returns must be ignored.
        applyStimulus(19'd0, 19'd50, 19'd700, 19'd4, 4, 1'b0, 1'b1);
        iDmaEn = 1'b1;
        for (int c = 0; c < 50 && accQ.size() < 3; c++) tick();
        checkOutput("t6_pre_vd", 32'(ufi.oMUfiVd), 1);
        iSysRst = 1'b1;
        iDmaEn  = 1'b0;
        #4;
        checkOutput("t6_adrs", ufi.oMUfiAdrs, 0);
        checkOutput("t6_red", 32'(ufi.oMUfiREd), 0);
        checkOutput("t6_vd", 32'(ufi.oMUfiVd), 0);
        checkOutput("t6_cmd", 32'(ufi.oMUfiCmd), 1);
        checkOutput("t6_pixvd", 32'(ufi.oPixVd), 0);
        checkOutput("t6_sel", 32'(oFrameSel), 0);
        checkOutput("t6_done", 32'(oFrameDone), 0);
        checkOutput("t6_ovf", 32'(oOverflow), 0);
        tick();
        pixQ.delete();
        iSysRst = 1'b0;
        tick(10);
        checkOutput("t6_stray_ovf", 32'(oOverflow), 0);
        checkOutput("t6_stray_pixvd", 32'(ufi.oPixVd), 0);
        checkOutput("t6_stray_pix_cnt", pixQ.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
